prog_tick_counter: RTL and testbench

//  Parametrised successor of the limit-select counter. It generates a 1-cycle tick every LIMIT[sel]+1 enabled

---
 rtl/prog_tick_counter_pkg.sv | 12 +
 rtl/prog_tick_counter_limit_table.sv | 21 ++
 rtl/prog_tick_counter.sv | 104 ++++++++++
 tb/tb_prog_tick_counter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_tick_counter_pkg.sv
// Shared types and constants for the programmable tick counter.
package counter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/prog_tick_counter_limit_table.sv
// Combinational lookup of one period limit from a packed parameter table.
module limit_table #(
    parameter int NB_COUNT = 32,
    parameter int NB_SEL   = 2,
    parameter logic [NB_COUNT*(2**NB_SEL)-1:0] LIMITS = {32'd63, 32'd31, 32'd15, 32'd7}
) (
    input  logic [NB_SEL-1:0]   sel_i,
    output logic [NB_COUNT-1:0] limit_o
);

    // Entry k sits at LIMITS[k*NB_COUNT +: NB_COUNT]; entry 0 is the least significant slice.
    always_comb begin
        limit_o = '0;
        for (int k = 0; k < 2**NB_SEL; k++) begin
            if (sel_i == NB_SEL'(k)) begin
                limit_o = LIMITS[k*NB_COUNT +: NB_COUNT];
            end
        end
    end

endmodule

// File: rtl/prog_tick_counter.sv
// Programmable periodic strobe: one-cycle tick every LIMIT[sel]+1 enabled clocks,
// with continuous and one-shot modes, period-boundary reloads and a wrapping tick counter.
module prog_tick_counter
    import counter_pkg::*;
#(
    parameter int NB_COUNT = 32,
    parameter int NB_SEL   = 2,
    parameter logic [NB_COUNT*(2**NB_SEL)-1:0] LIMITS = {32'd63, 32'd31, 32'd15, 32'd7},
    parameter int NB_TICKS = 8
) (
    input  logic                clk,
    input  logic                i_ck_reset,
    input  logic                i_count_enable,
    input  logic [NB_SEL-1:0]   i_count_sel,
    input  logic                i_mode,
    input  logic                i_start,
    output logic                o_shift_enable,
    output logic                o_busy,
    output logic [NB_COUNT-1:0] o_count,
    output logic [NB_TICKS-1:0] o_tick_cnt
);

    state_t              state_q, state_d;
    logic [NB_COUNT-1:0] count_q, count_d;
    logic [NB_SEL-1:0]   sel_lat_q, sel_lat_d;
    logic                mode_lat_q, mode_lat_d;
    logic                tick_q, tick_d;
    logic [NB_TICKS-1:0] tick_cnt_q, tick_cnt_d;
    logic [NB_COUNT-1:0] limit;
    logic                wrap;

    limit_table #(
        .NB_COUNT (NB_COUNT),
        .NB_SEL   (NB_SEL),
        .LIMITS   (LIMITS)
    ) u_limit_table (
        .sel_i   (sel_lat_q),
        .limit_o (limit)
    );

    assign wrap = (state_q == RUN) && i_count_enable && (count_q == limit);

    // Latches reload only on entry to RUN and at a wrap, so live selector/mode
    // changes never disturb the period in progress.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sel_lat_d  = sel_lat_q;
        mode_lat_d = mode_lat_q;
        tick_d     = 1'b0;
        tick_cnt_d = tick_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_count_enable && ((i_mode == MODE_CONT) || i_start)) begin
                    state_d    = RUN;
                    sel_lat_d  = i_count_sel;
                    mode_lat_d = i_mode;
                end
            end
            RUN: begin
                if (wrap) begin
                    count_d    = '0;
                    tick_d     = 1'b1;
                    tick_cnt_d = tick_cnt_q + NB_TICKS'(1);
                    sel_lat_d  = i_count_sel;
                    mode_lat_d = i_mode;
                    if (mode_lat_q == MODE_ONESHOT) begin
                        state_d = IDLE;
                    end
                end else if (i_count_enable) begin
                    count_d = count_q + NB_COUNT'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_ck_reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            sel_lat_q  <= i_count_sel;
            mode_lat_q <= i_mode;
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sel_lat_q  <= sel_lat_d;
            mode_lat_q <= mode_lat_d;
            tick_q     <= tick_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign o_shift_enable = tick_q;
    assign o_busy         = (state_q == RUN);
    assign o_count        = count_q;
    assign o_tick_cnt     = tick_cnt_q;

endmodule

// File: tb/tb_prog_tick_counter.sv
// Directed bench: instance A uses the default limit table {63,31,15,7}; instance B has entry 0 set to 0.
`timescale 1ns/1ps
module tb_prog_tick_counter;
    import counter_pkg::*;

    localparam int NB_COUNT = 32;
    localparam int NB_SEL   = 2;
    localparam int NB_TICKS = 8;
    localparam logic [127:0] LIMITS_A = {32'd63, 32'd31, 32'd15, 32'd7};
    localparam logic [127:0] LIMITS_B = {32'd63, 32'd31, 32'd15, 32'd0};

    logic clk = 1'b0;

    logic        resetA, enableA, modeA, startA;
    logic [1:0]  selA;
    logic        shiftA, busyA;
    logic [31:0] countA;
    logic [7:0]  tickCntA;

    logic        resetB, enableB, modeB, startB;
    logic [1:0]  selB;
    logic        shiftB, busyB;
    logic [31:0] countB;
    logic [7:0]  tickCntB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_tick_counter #(
        .NB_COUNT (NB_COUNT), .NB_SEL (NB_SEL), .LIMITS (LIMITS_A), .NB_TICKS (NB_TICKS)
    ) dutA (
        .clk (clk), .i_ck_reset (resetA), .i_count_enable (enableA), .i_count_sel (selA),
        .i_mode (modeA), .i_start (startA), .o_shift_enable (shiftA), .o_busy (busyA),
        .o_count (countA), .o_tick_cnt (tickCntA)
    );

    prog_tick_counter #(
        .NB_COUNT (NB_COUNT), .NB_SEL (NB_SEL), .LIMITS (LIMITS_B), .NB_TICKS (NB_TICKS)
    ) dutB (
        .clk (clk), .i_ck_reset (resetB), .i_count_enable (enableB), .i_count_sel (selB),
        .i_mode (modeB), .i_start (startB), .o_shift_enable (shiftB), .o_busy (busyB),
        .o_count (countB), .o_tick_cnt (tickCntB)
    );

    // Holds reset for 10 cycles and releases it; the next negedge is cycle k=1 after release.
    task automatic resetDutA(input logic [1:0] sel, input logic mode);
        @(negedge clk);
        resetA  = 1'b1;
        selA    = sel;
        modeA   = mode;
        enableA = 1'b1;
        startA  = 1'b0;
        repeat (10) @(negedge clk);
        resetA = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] expCount;
        logic        expShift;
        logic [7:0]  expTick;
        @(negedge clk);
        resetA = 1'b1; selA = 2'd0; modeA = MODE_CONT; enableA = 1'b1; startA = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({shiftA, busyA} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_flags shift/busy=%b required 00", {shiftA, busyA});
        end
        checks++;
        if (countA !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_count count=%0d required 0", countA);
        end
        checks++;
        if (tickCntA !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_tickcnt tick_cnt=%0d required 0", tickCntA);
        end
        resetA = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            expCount = 32'((k - 1) % 8);
            expShift = (k > 1) && (((k - 1) % 8) == 0);
            expTick  = 8'((k - 1) / 8);
            checks++;
            if (countA !== expCount || shiftA !== expShift || tickCntA !== expTick || busyA !== 1'b1) begin
                errors++;
                $display("[TB] FAIL cont_lim7 k=%0d count=%0d/%0d shift=%b/%b tick=%0d/%0d busy=%b/1",
                         k, countA, expCount, shiftA, expShift, tickCntA, expTick, busyA);
            end
        end
    endtask

    task automatic test_sel_change();
        logic [31:0] expCount;
        logic        expShift;
        resetDutA(2'd0, MODE_CONT);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            expCount = (k <= 8) ? 32'(k - 1) : (k <= 72) ? 32'(k - 9) : 32'(k - 73);
            expShift = (k == 9) || (k == 73);
            checks++;
            if (countA !== expCount || shiftA !== expShift) begin
                errors++;
                $display("[TB] FAIL sel_change k=%0d count=%0d/%0d shift=%b/%b",
                         k, countA, expCount, shiftA, expShift);
            end
            if (k == 4) selA = 2'd3;
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] expCount;
        logic        expShift, expBusy;
        logic [7:0]  expTick;
        resetDutA(2'd2, MODE_ONESHOT);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (busyA !== 1'b0 || countA !== 32'd0 || shiftA !== 1'b0) begin
                errors++;
                $display("[TB] FAIL oneshot_idle k=%0d busy=%b count=%0d shift=%b required 0/0/0",
                         k, busyA, countA, shiftA);
            end
        end
        startA = 1'b1;
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            expBusy  = (j <= 32);
            expCount = (j <= 32) ? 32'(j - 1) : 32'd0;
            expShift = (j == 33);
            expTick  = (j >= 33) ? 8'd1 : 8'd0;
            checks++;
            if (busyA !== expBusy || countA !== expCount || shiftA !== expShift || tickCntA !== expTick) begin
                errors++;
                $display("[TB] FAIL oneshot_run j=%0d busy=%b/%b count=%0d/%0d shift=%b/%b tick=%0d/%0d",
                         j, busyA, expBusy, countA, expCount, shiftA, expShift, tickCntA, expTick);
            end
            // Retriggers mid-run and on the wrap edge must both be dropped.
            startA = (j == 10) || (j == 32);
        end
        enableA = 1'b0;
        startA  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (busyA !== 1'b0 || shiftA !== 1'b0) begin
                errors++;
                $display("[TB] FAIL start_no_enable k=%0d busy=%b shift=%b required 0/0", k, busyA, shiftA);
            end
        end
        enableA = 1'b1;
        startA  = 1'b0;
    endtask

    task automatic test_pause();
        logic [31:0] expCount;
        logic        expShift;
        resetDutA(2'd2, MODE_CONT);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            expCount = (k <= 11) ? 32'(k - 1) : (k <= 16) ? 32'd10 : (k <= 37) ? 32'(k - 6) : 32'(k - 38);
            expShift = (k == 38);
            checks++;
            if (countA !== expCount || shiftA !== expShift || busyA !== 1'b1) begin
                errors++;
                $display("[TB] FAIL pause k=%0d count=%0d/%0d shift=%b/%b busy=%b/1",
                         k, countA, expCount, shiftA, expShift, busyA);
            end
            if (k == 11) enableA = 1'b0;
            if (k == 16) enableA = 1'b1;
        end
        resetDutA(2'd0, MODE_CONT);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            expCount = (k <= 8) ? 32'(k - 1) : (k <= 10) ? 32'd7 : 32'(k - 11);
            expShift = (k == 11);
            checks++;
            if (countA !== expCount || shiftA !== expShift) begin
                errors++;
                $display("[TB] FAIL wrap_pause k=%0d count=%0d/%0d shift=%b/%b",
                         k, countA, expCount, shiftA, expShift);
            end
            if (k == 8)  enableA = 1'b0;
            if (k == 10) enableA = 1'b1;
        end
    endtask

    task automatic test_reset_midrun();
        resetDutA(2'd2, MODE_CONT);
        repeat (21) @(negedge clk);
        checks++;
        if (countA !== 32'd20) begin
            errors++;
            $display("[TB] FAIL midrun_pre count=%0d required 20", countA);
        end
        resetA = 1'b1;
        selA   = 2'd0;
        @(negedge clk);
        checks++;
        if (countA !== 32'd0 || busyA !== 1'b0 || shiftA !== 1'b0 || tickCntA !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset count=%0d busy=%b shift=%b tick=%0d required 0/0/0/0",
                     countA, busyA, shiftA, tickCntA);
        end
        resetA = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (countA !== 32'd7) begin
            errors++;
            $display("[TB] FAIL prewrap count=%0d required 7", countA);
        end
        resetA = 1'b1;
        @(negedge clk);
        checks++;
        if (shiftA !== 1'b0 || busyA !== 1'b0 || countA !== 32'd0) begin
            errors++;
            $display("[TB] FAIL wrap_reset shift=%b busy=%b count=%0d required 0/0/0", shiftA, busyA, countA);
        end
        resetA = 1'b0;
    endtask

    task automatic test_limit_zero();
        logic       expShift;
        logic [7:0] expTick;
        @(negedge clk);
        resetB = 1'b1; enableB = 1'b1; selB = 2'd0; modeB = MODE_CONT; startB = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busyB !== 1'b0 || shiftB !== 1'b0 || tickCntB !== 8'd0) begin
            errors++;
            $display("[TB] FAIL zero_reset busy=%b shift=%b tick=%0d required 0/0/0", busyB, shiftB, tickCntB);
        end
        resetB = 1'b0;
        for (int k = 1; k <= 301; k++) begin
            @(negedge clk);
            expShift = (k >= 2);
            expTick  = 8'(k - 1);
            checks++;
            if (shiftB !== expShift || tickCntB !== expTick || countB !== 32'd0 || busyB !== 1'b1) begin
                errors++;
                $display("[TB] FAIL zero_cont k=%0d shift=%b/%b tick=%0d/%0d count=%0d/0 busy=%b/1",
                         k, shiftB, expShift, tickCntB, expTick, countB, busyB);
            end
        end
        checks++;
        if (tickCntB !== 8'd44) begin
            errors++;
            $display("[TB] FAIL tick_wrap300 tick_cnt=%0d required 44", tickCntB);
        end
        enableB = 1'b0;
        @(negedge clk);
        checks++;
        if (shiftB !== 1'b0 || tickCntB !== 8'd44 || busyB !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_pause shift=%b tick=%0d busy=%b required 0/44/1", shiftB, tickCntB, busyB);
        end
        enableB = 1'b1;
        @(negedge clk);
        checks++;
        if (shiftB !== 1'b1 || tickCntB !== 8'd45) begin
            errors++;
            $display("[TB] FAIL zero_resume shift=%b tick=%0d required 1/45", shiftB, tickCntB);
        end
    endtask

    initial begin
        resetA = 1'b1; enableA = 1'b0; selA = 2'd0; modeA = MODE_CONT; startA = 1'b0;
        resetB = 1'b1; enableB = 1'b0; selB = 2'd0; modeB = MODE_CONT; startB = 1'b0;
        test_reset();
        test_sel_change();
        test_oneshot();
        test_pause();
        test_reset_midrun();
        test_limit_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
